// File: rtl/ysyx_24110006_defs.sv
// Shared definitions for the CSR/trap execution stage: op encodings, CSR
// type codes, CSR addresses, trap causes and FSM state encoding.
package ysyx_24110006_defs;

  // System-instruction op encodings on i_op
  localparam logic [2:0] OP_NONE    = 3'd0;
  localparam logic [2:0] OP_CSRRW   = 3'd1;
  localparam logic [2:0] OP_CSRRS   = 3'd2;
  localparam logic [2:0] OP_CSRRC   = 3'd3;
  localparam logic [2:0] OP_ECALL   = 3'd4;
  localparam logic [2:0] OP_MRET    = 3'd5;
  localparam logic [2:0] OP_ILLEGAL = 3'd7;

  // Operation type presented to the CSR file
  localparam logic [1:0] CSR_T_MRET  = 2'b00;
  localparam logic [1:0] CSR_T_CSRW  = 2'b01;
  localparam logic [1:0] CSR_T_ECALL = 2'b11;

  // Machine-mode CSR addresses
  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  // Trap cause values
  localparam logic [31:0] CAUSE_ECALL   = 32'd11;
  localparam logic [31:0] CAUSE_ILLEGAL = 32'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  function automatic logic is_csr_op(input logic [2:0] op);
    return (op == OP_CSRRW) || (op == OP_CSRRS) || (op == OP_CSRRC);
  endfunction

  // NONE and the unassigned codes all collapse onto a single illegal op
  function automatic logic [2:0] canon_op(input logic [2:0] op);
    return (is_csr_op(op) || (op == OP_ECALL) || (op == OP_MRET)) ? op : OP_ILLEGAL;
  endfunction

  function automatic logic [1:0] csr_type(input logic [2:0] op);
    if (is_csr_op(op)) return CSR_T_CSRW;
    if (op == OP_MRET) return CSR_T_MRET;
    return CSR_T_ECALL;
  endfunction

endpackage

// File: rtl/csr_alu.sv
// Combinational CSR modify unit: new CSR value and write enable for the
// CSRRW/CSRRS/CSRRC family. Non-CSR ops produce no write.
module csr_alu
  import ysyx_24110006_defs::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] old_val,
  input  logic [31:0] rs1,
  input  logic        rs1_x0,
  output logic [31:0] wdata,
  output logic        wen
);

  // Bitwise modify; set/clear with rs1=x0 is a pure read
  always_comb begin
    wdata = '0;
    wen   = 1'b0;
    case (op)
      OP_CSRRW: begin
        wdata = rs1;
        wen   = 1'b1;
      end
      OP_CSRRS: begin
        wdata = old_val | rs1;
        wen   = ~rs1_x0;
      end
      OP_CSRRC: begin
        wdata = old_val & ~rs1;
        wen   = ~rs1_x0;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/trap_ctrl.sv
// Multi-cycle CSR/trap stage: IDLE -> READ -> WRITE -> RESP.
// Handshakes: a request transfers on a cycle with i_valid && o_ready
// (o_ready is high only in IDLE); a result transfers on a cycle with
// o_valid && i_ready, and o_valid/o_rd_data stay stable until then.
module trap_ctrl
  import ysyx_24110006_defs::*;
#(
  parameter logic [31:0] MCAUSE_ECALL   = CAUSE_ECALL,
  parameter logic [31:0] MCAUSE_ILLEGAL = CAUSE_ILLEGAL
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [2:0]  i_op,
  input  logic [31:0] i_pc,
  input  logic [11:0] i_csr,
  input  logic [31:0] i_rs1,
  input  logic        i_rs1_x0,
  output logic        o_csr_valid,
  output logic [1:0]  o_csr_t,
  output logic [11:0] o_csr,
  output logic [31:0] o_csr_pc,
  output logic [31:0] o_csr_wdata,
  output logic [31:0] o_mcause,
  input  logic [31:0] i_csr_rdata,
  input  logic [31:0] i_csr_upc,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [31:0] o_rd_data,
  output logic        o_redirect,
  output logic [31:0] o_redirect_pc,
  output logic [1:0]  o_dbg_state
);

  state_t      state_q, state_d;
  logic [2:0]  op_q;
  logic [31:0] pc_q;
  logic [11:0] csr_q;
  logic [31:0] rs1_q;
  logic        rs1_x0_q;
  logic [31:0] old_q;
  logic [31:0] target_q;
  logic        first_q;
  logic [31:0] alu_wdata;
  logic        alu_wen;

  csr_alu u_csr_alu (
    .op      (op_q),
    .old_val (old_q),
    .rs1     (rs1_q),
    .rs1_x0  (rs1_x0_q),
    .wdata   (alu_wdata),
    .wen     (alu_wen)
  );

  // State register; reset aborts any operation in flight
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Request capture, CSR read capture and first-RESP-cycle marker
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      op_q     <= '0;
      pc_q     <= '0;
      csr_q    <= '0;
      rs1_q    <= '0;
      rs1_x0_q <= 1'b0;
      old_q    <= '0;
      target_q <= '0;
      first_q  <= 1'b0;
    end else begin
      // RESP is only ever entered from WRITE, so this marks its first cycle
      first_q <= (state_q == ST_WRITE);
      if ((state_q == ST_IDLE) && i_valid) begin
        op_q     <= canon_op(i_op);
        pc_q     <= i_pc;
        csr_q    <= i_csr;
        rs1_q    <= i_rs1;
        rs1_x0_q <= i_rs1_x0;
      end
      if (state_q == ST_READ) begin
        old_q    <= i_csr_rdata;
        target_q <= i_csr_upc;
      end
    end
  end

  // Next state and all outputs, decoded from the registered state
  always_comb begin
    state_d       = state_q;
    o_ready       = 1'b0;
    o_csr_valid   = 1'b0;
    o_csr_t       = CSR_T_MRET;
    o_csr         = '0;
    o_csr_pc      = '0;
    o_csr_wdata   = '0;
    o_mcause      = '0;
    o_valid       = 1'b0;
    o_rd_data     = '0;
    o_redirect    = 1'b0;
    o_redirect_pc = '0;
    case (state_q)
      ST_IDLE: begin
        o_ready = 1'b1;
        if (i_valid) state_d = ST_READ;
      end
      ST_READ: begin
        o_csr   = csr_q;
        o_csr_t = csr_type(op_q);
        state_d = ST_WRITE;
      end
      ST_WRITE: begin
        o_csr   = csr_q;
        o_csr_t = csr_type(op_q);
        if (is_csr_op(op_q)) begin
          o_csr_valid = alu_wen;
          o_csr_wdata = alu_wdata;
        end else if (op_q != OP_MRET) begin
          // ECALL or illegal: CSR file records mepc and mcause
          o_csr_valid = 1'b1;
          o_csr_pc    = pc_q;
          o_mcause    = (op_q == OP_ECALL) ? MCAUSE_ECALL : MCAUSE_ILLEGAL;
        end
        state_d = ST_RESP;
      end
      ST_RESP: begin
        o_valid = 1'b1;
        if (is_csr_op(op_q)) o_rd_data = old_q;
        if (first_q && !is_csr_op(op_q)) begin
          o_redirect    = 1'b1;
          o_redirect_pc = target_q;
        end
        if (i_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl with a stub CSR file, a transaction-level
// model producing per-cycle expected outputs, and literal spot checks.
module tb_trap_ctrl;
  import ysyx_24110006_defs::*;

  logic        i_clock, i_reset, i_valid, i_rs1_x0, i_ready;
  logic [2:0]  i_op;
  logic [31:0] i_pc, i_rs1, i_csr_rdata, i_csr_upc;
  logic [11:0] i_csr;
  logic        o_ready, o_csr_valid, o_valid, o_redirect;
  logic [1:0]  o_csr_t, o_dbg_state;
  logic [11:0] o_csr;
  logic [31:0] o_csr_pc, o_csr_wdata, o_mcause, o_rd_data, o_redirect_pc;

  typedef struct packed {
    logic        ready;
    logic        csr_valid;
    logic [1:0]  csr_t;
    logic [11:0] csr;
    logic [31:0] csr_pc;
    logic [31:0] wdata;
    logic [31:0] mcause;
    logic        valid;
    logic [31:0] rd_data;
    logic        redirect;
    logic [31:0] redirect_pc;
  } out_t;

  out_t        exp_q[$];
  int          n_checks = 0;
  int          n_pass = 0;
  int          strobe_cnt = 0;
  int          exp_strobes = 0;
  int          redir_cnt = 0;
  logic [31:0] last_rd = '0;
  logic [31:0] last_redir_pc = '0;
  logic        prev_valid = 1'b0;
  logic [31:0] stub_csr [4] = '{default: 32'h0};
  logic [31:0] mdl_csr [4];

  trap_ctrl dut (
    .i_clock       (i_clock),
    .i_reset       (i_reset),
    .i_valid       (i_valid),
    .o_ready       (o_ready),
    .i_op          (i_op),
    .i_pc          (i_pc),
    .i_csr         (i_csr),
    .i_rs1         (i_rs1),
    .i_rs1_x0      (i_rs1_x0),
    .o_csr_valid   (o_csr_valid),
    .o_csr_t       (o_csr_t),
    .o_csr         (o_csr),
    .o_csr_pc      (o_csr_pc),
    .o_csr_wdata   (o_csr_wdata),
    .o_mcause      (o_mcause),
    .i_csr_rdata   (i_csr_rdata),
    .i_csr_upc     (i_csr_upc),
    .o_valid       (o_valid),
    .i_ready       (i_ready),
    .o_rd_data     (o_rd_data),
    .o_redirect    (o_redirect),
    .o_redirect_pc (o_redirect_pc),
    .o_dbg_state   (o_dbg_state)
  );

  // Clock
  initial begin
    i_clock = 1'b0;
    forever #5 i_clock = ~i_clock;
  end

  // Stub CSR file: combinational read by address, trap/return target by type
  always_comb begin
    i_csr_rdata = 32'h0;
    i_csr_upc   = 32'h0;
    case (o_csr)
      CSR_MSTATUS: i_csr_rdata = stub_csr[0];
      CSR_MTVEC:   i_csr_rdata = stub_csr[1];
      CSR_MEPC:    i_csr_rdata = stub_csr[2];
      CSR_MCAUSE:  i_csr_rdata = stub_csr[3];
      default: ;
    endcase
    if (o_csr_t == CSR_T_ECALL)     i_csr_upc = stub_csr[1];
    else if (o_csr_t == CSR_T_MRET) i_csr_upc = stub_csr[2];
  end

  // Stub CSR file: writes on the strobe
  always @(posedge i_clock) begin
    if (o_csr_valid) begin
      strobe_cnt <= strobe_cnt + 1;
      if (o_csr_t == CSR_T_CSRW) begin
        case (o_csr)
          CSR_MSTATUS: stub_csr[0] <= o_csr_wdata;
          CSR_MTVEC:   stub_csr[1] <= o_csr_wdata;
          CSR_MEPC:    stub_csr[2] <= o_csr_wdata;
          CSR_MCAUSE:  stub_csr[3] <= o_csr_wdata;
          default: ;
        endcase
      end else if (o_csr_t == CSR_T_ECALL) begin
        stub_csr[2] <= o_csr_pc;
        stub_csr[3] <= o_mcause;
      end
    end
  end

  // Scoreboard: every cycle, compare all outputs against the model
  always @(negedge i_clock) begin
    out_t act_v, exp_v;
    act_v = {o_ready, o_csr_valid, o_csr_t, o_csr, o_csr_pc, o_csr_wdata, o_mcause,
             o_valid, o_rd_data, o_redirect, o_redirect_pc};
    if (exp_q.size() > 0) exp_v = exp_q.pop_front();
    else begin
      exp_v = '0;
      exp_v.ready = 1'b1;
    end
    n_checks++;
    if (act_v === exp_v) n_pass++;
    else $display("FAIL outputs t=%0t state=%0d got=%h want=%h", $time, o_dbg_state, act_v, exp_v);
    if (o_valid && !prev_valid) last_rd = o_rd_data;
    prev_valid = o_valid;
    if (o_redirect) begin
      redir_cnt++;
      last_redir_pc = o_redirect_pc;
    end
  end

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s got=%h want=%h", name, act, exp);
  endtask

  function automatic int csr_slot(input logic [11:0] a);
    case (a)
      12'h300: return 0;
      12'h305: return 1;
      12'h341: return 2;
      12'h342: return 3;
      default: return -1;
    endcase
  endfunction

  // Model one instruction from the architectural rules, then drive it.
  // Called at posedge+1 with the stage idle; returns at posedge+1 idle.
  // d = number of RESP cycles with i_ready held low.
  task automatic issue(input logic [2:0] op, input logic [31:0] pc, input logic [11:0] addr,
                       input logic [31:0] rs1, input logic x0, input int d);
    out_t        r;
    logic        is_csr, is_mret, is_trap, strobe;
    logic [31:0] old, wd, target, cause;
    logic [1:0]  t;
    int          slot;
    slot    = csr_slot(addr);
    is_csr  = (op >= 3'd1) && (op <= 3'd3);
    is_mret = (op == 3'd5);
    is_trap = !is_csr && !is_mret;
    old     = (slot >= 0) ? mdl_csr[slot] : 32'h0;
    t       = is_csr ? 2'b01 : (is_mret ? 2'b00 : 2'b11);
    wd      = 32'h0;
    strobe  = 1'b0;
    cause   = 32'h0;
    if (op == 3'd1) begin wd = rs1;        strobe = 1'b1; end
    if (op == 3'd2) begin wd = old | rs1;  strobe = !x0;  end
    if (op == 3'd3) begin wd = old & ~rs1; strobe = !x0;  end
    if (is_trap) begin
      strobe = 1'b1;
      cause  = (op == 3'd4) ? 32'd11 : 32'd2;
    end
    target = is_trap ? mdl_csr[1] : (is_mret ? mdl_csr[2] : 32'h0);

    i_valid  = 1'b1;
    i_op     = op;
    i_pc     = pc;
    i_csr    = addr;
    i_rs1    = rs1;
    i_rs1_x0 = x0;
    i_ready  = 1'b0;
    @(posedge i_clock); #1;

    // READ, WRITE, then d+1 RESP cycles
    r = '0;
    r.csr   = addr;
    r.csr_t = t;
    exp_q.push_back(r);
    r.csr_valid = strobe;
    r.wdata     = wd;
    r.csr_pc    = is_trap ? pc : 32'h0;
    r.mcause    = cause;
    exp_q.push_back(r);
    r = '0;
    r.valid       = 1'b1;
    r.rd_data     = is_csr ? old : 32'h0;
    r.redirect    = !is_csr;
    r.redirect_pc = is_csr ? 32'h0 : target;
    exp_q.push_back(r);
    r.redirect    = 1'b0;
    r.redirect_pc = 32'h0;
    for (int k = 0; k < d; k++) exp_q.push_back(r);

    if (strobe) begin
      exp_strobes++;
      if (is_csr) begin
        if (slot >= 0) mdl_csr[slot] = wd;
      end else begin
        mdl_csr[2] = pc;
        mdl_csr[3] = cause;
      end
    end

    // Junk requests while busy must be ignored
    i_op     = 3'($urandom_range(0, 7));
    i_pc     = $urandom;
    i_csr    = 12'($urandom);
    i_rs1    = $urandom;
    i_rs1_x0 = 1'($urandom_range(0, 1));
    @(posedge i_clock); #1;
    @(posedge i_clock); #1;
    i_valid = 1'b0;
    i_ready = (d == 0);
    repeat (d) begin
      @(posedge i_clock); #1;
    end
    i_ready = 1'b1;
    @(posedge i_clock); #1;
    i_ready = 1'b0;
  endtask

  initial begin
    int rc0;
    for (int k = 0; k < 4; k++) mdl_csr[k] = 32'h0;
    i_reset  = 1'b0;
    i_valid  = 1'b0;
    i_op     = OP_NONE;
    i_pc     = '0;
    i_csr    = '0;
    i_rs1    = '0;
    i_rs1_x0 = 1'b0;
    i_ready  = 1'b0;
    @(posedge i_clock); #1;
    check32("reset_ready", {31'h0, o_ready}, 32'h1);
    check32("reset_valid_strobe", {30'h0, o_valid, o_csr_valid}, 32'h0);
    repeat (2) @(posedge i_clock);
    #1 i_reset = 1'b1;

    issue(OP_CSRRW, 32'h8000_0000, CSR_MTVEC, 32'h8000_0100, 1'b0, 0);
    check32("csrrw_rd", last_rd, 32'h0);
    check32("csrrw_mtvec", stub_csr[1], 32'h8000_0100);
    check32("csrrw_no_redirect", 32'(redir_cnt), 32'h0);

    issue(OP_CSRRW, 32'h8000_0004, CSR_MSTATUS, 32'h0000_1800, 1'b0, 0);
    issue(OP_CSRRS, 32'h8000_0008, CSR_MSTATUS, 32'h0000_0008, 1'b0, 0);
    check32("csrrs_rd", last_rd, 32'h0000_1800);
    check32("csrrs_mstatus", stub_csr[0], 32'h0000_1808);

    issue(OP_CSRRW, 32'h8000_000c, CSR_MSTATUS, 32'h0000_1800, 1'b0, 0);
    issue(OP_CSRRS, 32'h8000_0010, CSR_MSTATUS, 32'h0000_0008, 1'b1, 0);
    check32("csrrs_x0_rd", last_rd, 32'h0000_1800);
    check32("csrrs_x0_mstatus", stub_csr[0], 32'h0000_1800);

    issue(OP_CSRRC, 32'h8000_0014, CSR_MSTATUS, 32'h0000_0800, 1'b0, 2);
    check32("csrrc_rd", last_rd, 32'h0000_1800);
    check32("csrrc_mstatus", stub_csr[0], 32'h0000_1000);

    // Reset while in WRITE: no strobe may land, stage returns to idle
    i_valid = 1'b1;
    i_op    = OP_CSRRW;
    i_pc    = 32'h8000_0018;
    i_csr   = CSR_MSTATUS;
    i_rs1   = 32'hdead_beef;
    begin
      out_t r;
      r = '0;
      r.csr   = CSR_MSTATUS;
      r.csr_t = 2'b01;
      @(posedge i_clock); #1;
      exp_q.push_back(r);
    end
    i_valid = 1'b0;
    @(posedge i_clock); #1;
    i_reset = 1'b0;
    exp_q.delete();
    repeat (2) begin
      @(posedge i_clock); #1;
    end
    i_reset = 1'b1;
    @(posedge i_clock); #1;
    check32("abort_mstatus", stub_csr[0], 32'h0000_1000);
    check32("abort_strobes", 32'(strobe_cnt), 32'(exp_strobes));
    check32("abort_ready", {31'h0, o_ready}, 32'h1);

    issue(OP_ECALL, 32'h8000_0020, 12'h000, 32'h0, 1'b0, 0);
    check32("ecall_mepc", stub_csr[2], 32'h8000_0020);
    check32("ecall_mcause", stub_csr[3], 32'd11);
    check32("ecall_target", last_redir_pc, 32'h8000_0100);
    check32("ecall_rd", last_rd, 32'h0);

    issue(OP_CSRRW, 32'h8000_0100, CSR_MEPC, 32'h8000_0024, 1'b0, 0);
    check32("mepc_rd", last_rd, 32'h8000_0020);

    issue(OP_MRET, 32'h8000_0104, CSR_MCAUSE, 32'h0, 1'b0, 0);
    check32("mret_target", last_redir_pc, 32'h8000_0024);
    check32("mret_no_write", stub_csr[3], 32'd11);

    issue(3'd7, 32'h8000_0044, 12'h000, 32'h0, 1'b0, 0);
    check32("illegal_mcause", stub_csr[3], 32'd2);
    check32("illegal_mepc", stub_csr[2], 32'h8000_0044);
    check32("illegal_target", last_redir_pc, 32'h8000_0100);
    check32("illegal_rd", last_rd, 32'h0);

    rc0 = redir_cnt;
    issue(OP_ECALL, 32'h8000_0050, 12'h000, 32'h0, 1'b0, 5);
    check32("stall_one_redirect", 32'(redir_cnt - rc0), 32'h1);
    check32("stall_mcause", stub_csr[3], 32'd11);

    issue(OP_NONE, 32'h8000_0060, 12'h000, 32'h0, 1'b0, 0);
    check32("none_mcause", stub_csr[3], 32'd2);

    issue(OP_CSRRC, 32'h8000_0064, 12'h7c0, 32'hffff_ffff, 1'b1, 1);
    check32("unmapped_rd", last_rd, 32'h0);
    issue(OP_CSRRW, 32'h8000_0068, CSR_MCAUSE, 32'h0000_0005, 1'b1, 0);
    check32("csrrw_x0_writes", stub_csr[3], 32'h0000_0005);
    check32("final_strobes", 32'(strobe_cnt), 32'(exp_strobes));

    repeat (2) @(posedge i_clock);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Bound the run
  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
